pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Sequences the board PLL on the 50 MHz reference clock. It holds the PLL in reset after power-up, then waits for `locked` and requires lock to stay stable for a qualification window. Only then does it release the system reset. It re-initialises the PLL on loss of lock or lock timeout, and declares a sticky fault after repeated failed attempts. It sits between the board clock and the PLL instance: it drives the PLL `rst` and produces the design-wide reset. That reset is in the `clkin` domain, so consumers in the 25 MHz domain re-synchronise it.

## Interface
Parameters:
- `RST_HOLD`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_STABLE`, 1024: consecutive synchronised-locked cycles required before release (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK plus STABLE per attempt before retry (≥1).
- `MAX_RETRY`, 4: consecutive timeouts that trigger FAULT (1..15).

Ports:
- `clkin` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock indicator; asynchronous to `clkin`.
- `reinit` in 1: synchronous one-cycle request to restart the sequence.
- `pll_rst` out 1: active-high PLL reset.
- `sys_rst_n` out 1: active-low system reset, registered in `clkin` domain.
- `ready` out 1: high in RUN only.
- `fault` out 1: high in FAULT only.
- `retry_cnt` out 4: consecutive timeout count.
- `lost_cnt` out 8: loss-of-lock events in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-flop synchroniser to give `lock_s`. Only `lock_s` is used.
- All outputs are registered and decoded from the state register.
- States:
  - RESET: `pll_rst`=1, `sys_rst_n`=0. After `RST_HOLD` cycles in RESET, go to WAIT_LOCK. The timeout counter clears on entry.
  - WAIT_LOCK: `pll_rst`=0. If `lock_s`=1, go to STABLE with the stable counter at 0.
  - STABLE: `pll_rst`=0. If `lock_s`=0, return to WAIT_LOCK; the stable counter resets, the timeout counter keeps running. If `lock_s`=1 and the stable counter equals `LOCK_STABLE`-1, go to RUN; otherwise increment the stable counter.
  - Timeout (WAIT_LOCK or STABLE): when the timeout counter reaches `LOCK_TIMEOUT`-1, increment `retry_cnt`. If the new value equals `MAX_RETRY`, go to FAULT; otherwise go to RESET.
  - RUN: `sys_rst_n`=1, `ready`=1, `pll_rst`=0. `retry_cnt` clears on entry. If `lock_s`=0, go to RESET and increment `lost_cnt` (saturating). Loss of lock does not touch `retry_cnt`.
  - FAULT: `pll_rst`=1, `sys_rst_n`=0, `fault`=1. Sticky; only `reinit` or `rst_n` exits.
- `reinit`=1 in any state moves to RESET and clears `retry_cnt`. It has priority over every other transition in the same cycle. `lost_cnt` is preserved.
- Timeout and lock qualification completing on the same edge: the RUN transition wins.
- Counters are sized by `$clog2` of their parameter and never wrap. Each counter resets on entry to its owning state.

## Timing
- Values while `rst_n`=0 and immediately after release:
  - state RESET, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0
  - `retry_cnt`=0, `lost_cnt`=0
  - all counters and synchroniser flops at 0
- Asserting `rst_n` mid-operation forces this state asynchronously, regardless of the current state.
- After `rst_n` release, `pll_rst` stays high for exactly `RST_HOLD` rising edges.
- `locked` rising to `ready`/`sys_rst_n` rising: `LOCK_STABLE`+2 edges after the first edge that samples `locked`=1. This assumes `locked` stays high.
- `locked` falling in RUN to `sys_rst_n` falling: 3 edges (2 for the synchroniser, 1 for the state register). `pll_rst` rises on the same edge.
- `reinit` sampled high: `pll_rst`=1 and `sys_rst_n`=0 from the next edge.
- `sys_rst_n` changes only on `clkin` edges and never glitches.

## Test plan
Run with `RST_HOLD`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=32, `MAX_RETRY`=3.
1. Power-up:
   - Stimulus: release `rst_n`; `locked` rises 10 cycles later and stays high.
   - Required: `pll_rst` is high for 4 cycles. `ready`=`sys_rst_n`=1 exactly 10 edges after `locked` is first sampled high. `retry_cnt`=0.
2. Glitchy lock:
   - Stimulus: `locked` high for 5 cycles, low for 3, then high permanently.
   - Required: STABLE aborts and restarts. `ready` rises 10 edges after the final rise, provided this stays within 32 cycles of WAIT_LOCK entry. No `retry_cnt` increment.
3. Timeout to fault:
   - Stimulus: hold `locked`=0.
   - Required: `retry_cnt` steps 1, 2, 3, each step after 4+32 cycles. On reaching 3, `fault`=1 and `pll_rst`=1 permanently.
   - Stimulus: pulse `reinit`.
   - Required: RESET, `retry_cnt`=0, `fault`=0.
4. Loss of lock:
   - Stimulus: in RUN, drop `locked`.
   - Required: `sys_rst_n` falls 3 edges later with `pll_rst`=1 and `lost_cnt`=1. Relock returns to RUN.
   - Stimulus: repeat 300 times.
   - Required: `lost_cnt` saturates at 255.
5. Simultaneous events:
   - Stimulus: `reinit` on the same edge as STABLE completion.
   - Required: RESET, not RUN.
   - Stimulus: `reinit` together with a timeout.
   - Required: RESET, `retry_cnt`=0.
6. Async reset mid-STABLE:
   - Stimulus: assert `rst_n`=0 during STABLE.
   - Required: outputs take reset values immediately, without waiting for a `clkin` edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Board PLL reset/lock sequencer on the reference clock: holds the PLL in reset, qualifies lock,
// releases the design-wide reset, and retries on timeout or lost lock until a sticky fault.
module pll_lock_sequencer #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 4
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       reinit,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          sync1;
  logic          lock_s;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;
  logic          searching;
  logic          qualify;
  logic          timeout;

  // locked is asynchronous to clkin; only the second flop's output is ever used.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= locked;
      lock_s <= sync1;
    end
  end

  assign searching = (state == S_WAIT_LOCK) || (state == S_STABLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    next_state = state;
    qualify    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      S_RESET:     if (hold_cnt == HOLD_LAST) next_state = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) next_state = S_STABLE;
      S_STABLE: begin
        if (!lock_s) begin
          next_state = S_WAIT_LOCK;
        end else if (stable_cnt == STABLE_LAST) begin
          next_state = S_RUN;
          qualify    = 1'b1;
        end
      end
      S_RUN:       if (!lock_s) next_state = S_RESET;
      S_FAULT:     next_state = S_FAULT;
      default:     next_state = S_RESET;
    endcase
    // Lock qualification finishing on the timeout edge still goes to RUN.
    if (searching && (to_cnt == TO_LAST) && !qualify) begin
      timeout    = 1'b1;
      next_state = ((retry_cnt + 4'd1) == RETRY_LIMIT) ? S_FAULT : S_RESET;
    end
    if (reinit) next_state = S_RESET;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      hold_cnt   <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      state      <= next_state;
      // Each counter runs only while its owner state persists and restarts on (re)entry.
      hold_cnt   <= (state == S_RESET && next_state == S_RESET && !reinit)
                    ? hold_cnt + HW'(1) : '0;
      stable_cnt <= (state == S_STABLE && next_state == S_STABLE)
                    ? stable_cnt + SW'(1) : '0;
      to_cnt     <= (searching && (next_state == S_WAIT_LOCK || next_state == S_STABLE))
                    ? to_cnt + TW'(1) : '0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      lost_cnt  <= '0;
    end else begin
      if (reinit) begin
        retry_cnt <= '0;
      end else if (timeout) begin
        retry_cnt <= retry_cnt + 4'd1;
      end else if (next_state == S_RUN && state != S_RUN) begin
        retry_cnt <= '0;
      end
      if (state == S_RUN && next_state == S_RESET && !reinit && lost_cnt != 8'hFF) begin
        lost_cnt <= lost_cnt + 8'd1;
      end
    end
  end

  // Outputs are flops loaded from the next state, so they track the state register exactly
  // and sys_rst_n can only change on a clkin edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst   <= (next_state == S_RESET) || (next_state == S_FAULT);
      sys_rst_n <= (next_state == S_RUN);
      ready     <= (next_state == S_RUN);
      fault     <= (next_state == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-plus-random bench for pll_lock_sequencer; expected values come from the timing rules
// (latencies, attempt lengths, saturating counts) evaluated with plain arithmetic.
module tb_pll_lock_sequencer;

  localparam int RST_HOLD     = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 3;

  localparam int READY_LAT   = LOCK_STABLE + 2;          // first locked sample -> ready
  localparam int ATTEMPT     = RST_HOLD + LOCK_TIMEOUT;  // edges per failed attempt
  localparam int RELOCK_LAT  = RST_HOLD + LOCK_STABLE;   // reinit with lock held -> one edge before RUN
  localparam int LOST_EVENTS = 300;
  localparam int WAIT_BUDGET = 100;

  logic       clkin  = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       reinit = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_lost = 0;

  pll_lock_sequencer #(
    .RST_HOLD    (RST_HOLD),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .locked   (locked),
    .reinit   (reinit),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .lost_cnt (lost_cnt)
  );

  always #10 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // {pll_rst, sys_rst_n, ready, fault}
  function automatic logic [3:0] outs();
    return {pll_rst, sys_rst_n, ready, fault};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < WAIT_BUDGET) begin
      tick();
      n++;
    end
    check(tag, ready, 1'b1);
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;

    // Reset values while rst_n is low
    #35;
    check("rst_outs", outs(), 4'b1000);
    check("rst_retry", retry_cnt, 0);
    check("rst_lost", lost_cnt, 0);

    // 1. Power-up: pll_rst high for RST_HOLD edges, lock 10 cycles after release
    @(negedge clkin);
    rst_n = 1'b1;
    for (int i = 1; i <= RST_HOLD; i++) begin
      tick();
      check($sformatf("pwr_pll_rst_e%0d", i), pll_rst, (i < RST_HOLD));
    end
    repeat (10 - RST_HOLD) tick();
    locked = 1'b1;
    repeat (READY_LAT) tick();
    check("pwr_ready_early", {ready, sys_rst_n}, 2'b00);
    tick();
    check("pwr_ready", {pll_rst, sys_rst_n, ready, fault}, 4'b0110);
    check("pwr_retry", retry_cnt, 0);

    // 2. Glitchy lock after a reinit, random quiet time before the first rise
    locked = 1'b0;
    pulse_reinit();
    check("reinit_resp", outs(), 4'b1000);
    repeat (RST_HOLD) tick();
    check("glitch_wait_lock", pll_rst, 1'b0);
    d = $urandom_range(0, 8);
    repeat (d) tick();
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    repeat (3) tick();
    locked = 1'b1;
    repeat (READY_LAT) tick();
    check("glitch_ready_early", ready, 1'b0);
    tick();
    check("glitch_ready", {sys_rst_n, ready}, 2'b11);
    check("glitch_retry", retry_cnt, 0);

    // 3. Timeouts to fault, then reinit out of fault
    locked = 1'b0;
    pulse_reinit();
    for (int k = 1; k <= MAX_RETRY; k++) begin
      repeat (ATTEMPT - 1) tick();
      check($sformatf("to_retry_before_%0d", k), retry_cnt, k - 1);
      tick();
      check($sformatf("to_retry_step_%0d", k), retry_cnt, k);
      check($sformatf("to_outs_%0d", k), outs(), {3'b100, k == MAX_RETRY});
    end
    locked = 1'b1;
    repeat (50) tick();
    check("fault_sticky", outs(), 4'b1001);
    check("fault_retry", retry_cnt, MAX_RETRY);
    pulse_reinit();
    check("fault_exit", outs(), 4'b1000);
    check("fault_exit_retry", retry_cnt, 0);
    repeat (RELOCK_LAT) tick();
    check("relock_early", ready, 1'b0);
    tick();
    check("relock_ready", ready, 1'b1);

    // 4. Loss of lock in RUN, then repeated until lost_cnt saturates
    locked = 1'b0;
    tick();
    tick();
    check("lol_before", sys_rst_n, 1'b1);
    tick();
    exp_lost = exp_lost + 1;
    check("lol_fall", {sys_rst_n, pll_rst}, 2'b01);
    check("lol_cnt", lost_cnt, exp_lost);
    locked = 1'b1;
    wait_ready("lol_relock");
    for (int i = 0; i < LOST_EVENTS; i++) begin
      locked = 1'b0;
      repeat (3 + $urandom_range(0, 3)) tick();
      locked = 1'b1;
      exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
      wait_ready("lol_rep_relock");
      check("lol_rep_cnt", lost_cnt, exp_lost);
    end
    check("lol_saturated", lost_cnt, 255);

    // 5a. reinit on the edge that completes qualification
    pulse_reinit();
    repeat (RELOCK_LAT) tick();
    pulse_reinit();
    check("sim_reinit_qual", outs(), 4'b1000);

    // 5b. reinit on the edge of the final (fault-causing) timeout
    locked = 1'b0;
    pulse_reinit();
    repeat (MAX_RETRY * ATTEMPT - 1) tick();
    check("sim_to_before", retry_cnt, MAX_RETRY - 1);
    pulse_reinit();
    check("sim_to_outs", outs(), 4'b1000);
    check("sim_to_retry", retry_cnt, 0);
    repeat (ATTEMPT - 1) tick();
    check("sim_to_restart_before", retry_cnt, 0);
    tick();
    check("sim_to_restart", retry_cnt, 1);

    // 6. Asynchronous reset while in STABLE (RESET entered on the previous edge)
    locked = 1'b1;
    repeat (5) tick();
    check("arst_pre_outs", outs(), 4'b0000);
    check("arst_pre_retry", retry_cnt, 1);
    check("arst_pre_lost", lost_cnt, 255);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_outs", outs(), 4'b1000);
    check("arst_retry", retry_cnt, 0);
    check("arst_lost", lost_cnt, 0);
    @(negedge clkin);
    rst_n = 1'b1;
    wait_ready("post_arst_ready");
    check("post_arst_lost", lost_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
